// File: rtl/seven_seg_mux.sv
// Time-multiplexed N-digit seven-segment driver with a tear-free
// double-buffered load, PWM brightness and selectable output polarity.
module seven_seg_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_LOG2   = 10,
    parameter int PWM_BITS       = 3,
    parameter bit ACTIVE_LOW_SEG = 1'b0,
    parameter bit ACTIVE_LOW_AN  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [4*NUM_DIGITS-1:0] display_value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [PWM_BITS-1:0]     brightness,
    input  logic                    load,
    output logic [7:0]              seven_seg,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0] SEG_OFF = ACTIVE_LOW_SEG ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF =
        ACTIVE_LOW_AN ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

    logic [REFRESH_LOG2-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, shad_val_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q, shad_dp_q;
    logic                    pend_valid_q;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    tick_q, tick_d;

    logic                    wrap;
    logic                    boundary;
    logic                    lit;
    logic [PWM_BITS-1:0]     phase;
    logic [3:0]              nib;
    logic [6:0]              glyph;

    assign wrap     = &presc_q;
    assign boundary = wrap && (idx_q == LAST_IDX);
    assign phase    = presc_q[REFRESH_LOG2-1 -: PWM_BITS];
    assign nib      = shad_val_q[{idx_q, 2'b00} +: 4];
    assign lit      = (phase <= brightness) && !blank[idx_q];

    always_comb begin
        glyph = 7'h00;
        unique case (nib)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            4'hF: glyph = 7'h71;
        endcase
    end

    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (wrap) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        // Dark slots drive both buses inactive so no segment ghosts.
        seg_d  = lit ? {shad_dp_q[idx_q], glyph} : 8'h00;
        seg_d  = seg_d ^ SEG_OFF;
        an_d   = lit ? (AN_ONE << idx_q) : '0;
        an_d   = an_d ^ AN_OFF;
        tick_d = (idx_q == '0) && (presc_q == '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            shad_val_q   <= '0;
            shad_dp_q    <= '0;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
            tick_q       <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            tick_q  <= tick_d;
            // Shadow only changes on the frame boundary.
            if (boundary) begin
                pend_valid_q <= 1'b0;
                if (load) begin
                    shad_val_q <= display_value;
                    shad_dp_q  <= dp_in;
                end else if (pend_valid_q) begin
                    shad_val_q <= pend_val_q;
                    shad_dp_q  <= pend_dp_q;
                end
            end else if (load) begin
                pend_val_q   <= display_value;
                pend_dp_q    <= dp_in;
                pend_valid_q <= 1'b1;
            end
        end
    end

    assign seven_seg  = seg_q;
    assign anode      = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Bench for seven_seg_mux: directed steps plus random traffic against
// a cycle-count based reference model; checks both polarities.
module tb_seven_seg_mux;

    localparam logic [6:0] SEGTAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] display_value;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic [1:0]  brightness;
    logic        load;
    logic [7:0]  seg_h, seg_l;
    logic [3:0]  an_h, an_l;
    logic        tick_h, tick_l;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seven_seg_mux #(
        .NUM_DIGITS(4), .REFRESH_LOG2(4), .PWM_BITS(2),
        .ACTIVE_LOW_SEG(1'b0), .ACTIVE_LOW_AN(1'b0)
    ) u_hi (
        .clk(clk), .rstn(rstn), .display_value(display_value),
        .dp_in(dp_in), .blank(blank), .brightness(brightness),
        .load(load), .seven_seg(seg_h), .anode(an_h),
        .frame_tick(tick_h)
    );

    seven_seg_mux #(
        .NUM_DIGITS(4), .REFRESH_LOG2(4), .PWM_BITS(2),
        .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)
    ) u_lo (
        .clk(clk), .rstn(rstn), .display_value(display_value),
        .dp_in(dp_in), .blank(blank), .brightness(brightness),
        .load(load), .seven_seg(seg_l), .anode(an_l),
        .frame_tick(tick_l)
    );

    // Reference model: time since reset decides digit and phase;
    // the word shown in a frame is the last one loaded before it began.
    int unsigned c;
    logic [15:0] latest_v, shown_v;
    logic [3:0]  latest_dp, shown_dp;
    logic        have;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_tick;

    function automatic logic [7:0] f_seg(int unsigned cc, logic [15:0] v,
                                         logic [3:0] dp, logic [3:0] bl,
                                         logic [1:0] br);
        int d;
        int ph;
        d  = int'((cc / 16) % 4);
        ph = int'((cc % 16) / 4);
        if (ph > int'(br) || bl[d]) return 8'h00;
        return {dp[d], SEGTAB[v[4*d +: 4]]};
    endfunction

    function automatic logic [3:0] f_an(int unsigned cc, logic [3:0] bl,
                                        logic [1:0] br);
        int d;
        int ph;
        d  = int'((cc / 16) % 4);
        ph = int'((cc % 16) / 4);
        if (ph > int'(br) || bl[d]) return 4'h0;
        return 4'(1 << d);
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c         <= 0;
            latest_v  <= '0;
            latest_dp <= '0;
            shown_v   <= '0;
            shown_dp  <= '0;
            have      <= 1'b0;
            exp_seg   <= 8'h00;
            exp_an    <= 4'h0;
            exp_tick  <= 1'b0;
        end else begin
            exp_seg  <= f_seg(c, shown_v, shown_dp, blank, brightness);
            exp_an   <= f_an(c, blank, brightness);
            exp_tick <= (c % 64) == 0;
            if ((c % 64) == 63) begin
                have <= 1'b0;
                if (load) begin
                    shown_v  <= display_value;
                    shown_dp <= dp_in;
                end else if (have) begin
                    shown_v  <= latest_v;
                    shown_dp <= latest_dp;
                end
            end else if (load) begin
                latest_v  <= display_value;
                latest_dp <= dp_in;
                have      <= 1'b1;
            end
            c <= c + 1;
        end
    end

    task automatic check(string tag, logic [7:0] got, logic [7:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h at %0t",
                   tag, got, want, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check("seg", seg_h, exp_seg);
        check("an", {4'h0, an_h}, {4'h0, exp_an});
        check("tick", {7'h0, tick_h}, {7'h0, exp_tick});
        check("seg_n", seg_l, ~exp_seg);
        check("an_n", {4'h0, an_l}, {4'h0, ~exp_an});
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        for (int i = 0; i < 130; i++) begin
            step();
            n++;
            if (tick_h) return;
        end
        check("tick_timeout", 8'h00, 8'h01);
    endtask

    task automatic pulse_load(logic [15:0] v, logic [3:0] dp);
        display_value = v;
        dp_in         = dp;
        load          = 1'b1;
        step();
        load          = 1'b0;
    endtask

    int n;
    int cnt0, cnt1, bad;
    logic [3:0] an_want;

    initial begin
        rstn          = 1'b0;
        display_value = '0;
        dp_in         = '0;
        blank         = '0;
        brightness    = 2'd3;
        load          = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_seg", seg_h, 8'h00);
        check("rst_an", {4'h0, an_h}, 8'h00);
        check("rst_tick", {7'h0, tick_h}, 8'h00);
        check("rst_seg_n", seg_l, 8'hFF);
        check("rst_an_n", {4'h0, an_l}, 8'h0F);
        rstn = 1'b1;

        step();
        check("f0_seg", seg_h, 8'h3F);
        check("f0_an", {4'h0, an_h}, 8'h01);
        check("f0_tick", {7'h0, tick_h}, 8'h01);
        check("f0_seg_n", seg_l, 8'hC0);
        check("f0_an_n", {4'h0, an_l}, 8'h0E);
        for (int k = 1; k < 4; k++) begin
            repeat (16) step();
            an_want = 4'(1 << k);
            check("f0_seg_k", seg_h, 8'h3F);
            check("f0_an_k", {4'h0, an_h}, {4'h0, an_want});
        end

        repeat (5) step();
        pulse_load(16'hA5C3, 4'b0100);
        wait_tick(n);
        check("ld_d0", seg_h, 8'h4F);
        check("ld_an0", {4'h0, an_h}, 8'h01);
        repeat (16) step();
        check("ld_d1", seg_h, 8'h39);
        repeat (16) step();
        check("ld_d2", seg_h, 8'hED);
        repeat (16) step();
        check("ld_d3", seg_h, 8'h77);
        wait_tick(n);
        wait_tick(n);
        check("tick_period", 8'(n), 8'd64);

        repeat (10) step();
        pulse_load(16'h1111, 4'b0000);
        repeat (5) step();
        pulse_load(16'h2222, 4'b0000);
        repeat (31) step();
        check("tear_d3", seg_h, 8'h77);
        wait_tick(n);
        check("tear_new", seg_h, 8'h5B);

        repeat (62) step();
        pulse_load(16'h8888, 4'b0001);
        step();
        check("bnd_tick", {7'h0, tick_h}, 8'h01);
        check("bnd_seg", seg_h, 8'hFF);

        for (int b = 0; b < 4; b++) begin
            if (b == 1) continue;
            brightness = 2'(b);
            wait_tick(n);
            cnt0 = int'(an_h[0]);
            repeat (15) begin
                step();
                cnt0 += int'(an_h[0]);
            end
            check("pwm_duty", 8'(cnt0), 8'(4 * (b + 1)));
        end

        blank = 4'b0010;
        wait_tick(n);
        cnt0 = 0;
        cnt1 = 0;
        bad  = 0;
        for (int j = 0; j < 64; j++) begin
            if (j > 0) step();
            cnt0 += int'(an_h[0]);
            cnt1 += int'(an_h[1]);
            if (j >= 16 && j < 32 && seg_h != 8'h00) bad++;
        end
        check("blank_an1", 8'(cnt1), 8'd0);
        check("blank_seg", 8'(bad), 8'd0);
        check("blank_an0", 8'(cnt0), 8'd16);
        blank = 4'b0000;

        repeat (20) step();
        pulse_load(16'hFFFF, 4'hF);
        repeat (3) step();
        #2 rstn = 1'b0;
        #1;
        check("mrst_seg", seg_h, 8'h00);
        check("mrst_an", {4'h0, an_h}, 8'h00);
        check("mrst_tick", {7'h0, tick_h}, 8'h00);
        check("mrst_seg_n", seg_l, 8'hFF);
        check("mrst_an_n", {4'h0, an_l}, 8'h0F);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        step();
        check("mrst_f0", seg_h, 8'h3F);
        repeat (63) step();
        wait_tick(n);
        check("mrst_f1", seg_h, 8'h3F);

        repeat (1500) begin
            load          = ($urandom_range(0, 15) == 0);
            display_value = 16'($urandom);
            dp_in         = 4'($urandom);
            if ($urandom_range(0, 39) == 0) brightness = 2'($urandom);
            if ($urandom_range(0, 99) == 0)
                blank = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
            step();
        end
        load = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_mux.md
Name: seven_seg_mux

Overview:
- Parametrised, time-multiplexed N-digit seven-segment driver; successor to the single-digit seven_seg.
- Takes a packed hex word and per-digit decimal-point and blank masks, decodes one digit per time slot, and drives the shared segment bus plus one-hot anodes.
- Adds three things the single-digit block lacks: a tear-free double-buffered load, PWM brightness control, and selectable output polarity.
- Sits between the rotational_encoder/control logic and the uio pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- REFRESH_LOG2, 10, log2 of clock cycles per digit slot; slot length = 2^REFRESH_LOG2 cycles.
- PWM_BITS, 3, brightness resolution; requires PWM_BITS <= REFRESH_LOG2.
- ACTIVE_LOW_SEG, 0, 1 inverts seven_seg (common-anode parts).
- ACTIVE_LOW_AN, 0, 1 inverts anode.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- display_value  in  4*NUM_DIGITS  hex nibbles; digit k = [4k+3:4k].
- dp_in  in  NUM_DIGITS  decimal point per digit.
- blank  in  NUM_DIGITS  1 = digit k dark; sampled live, not buffered.
- brightness  in  PWM_BITS  duty level; 0 = dimmest, all-ones = full.
- load  in  1  single-cycle strobe capturing display_value and dp_in.
- seven_seg  out  8  bit0..6 = segments a..g, bit7 = dp.
- anode  out  NUM_DIGITS  one-hot digit enable.
- frame_tick  out  1  one-cycle pulse at each frame start.

Behaviour:
- Reset, asynchronous on rstn low:
  - prescaler, digit index, pending and shadow registers all 0.
  - pend_valid = 0, frame_tick = 0.
  - seven_seg and anode at the inactive level: all 0 when the polarity parameter is 0, all 1 when it is 1.
- Prescaler: REFRESH_LOG2-bit free-running up-counter.
  - On wrap (all-ones -> 0), the digit index advances; NUM_DIGITS-1 wraps to 0.
  - The index wrap is the frame boundary.
- Load buffering:
  - load=1 copies display_value/dp_in into the pending register and sets pend_valid. A later load before the boundary overwrites pending.
  - At the frame boundary, pending is copied to shadow if pend_valid, then pend_valid clears.
  - load coinciding with the boundary cycle writes straight to shadow and leaves pend_valid clear.
  - The display never shows a mix of old and new words within one frame.
- Decode, digit index i, active-high form gfedcba:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - bit7 = shadow dp[i].
- PWM:
  - phase = prescaler[REFRESH_LOG2-1 -: PWM_BITS].
  - Anode i is enabled iff phase <= brightness and blank[i]=0; otherwise all anodes are inactive.
  - Duty = (brightness+1)/2^PWM_BITS.
- Blanking: when a digit is blank or PWM-off, seven_seg is also driven inactive, which prevents ghosting.
- Latency: seven_seg and anode are registered, so they reflect the index/phase of the previous cycle (1-cycle latency).
- frame_tick: asserts, registered, in the same cycle the outputs first show digit 0 of a new frame.
- brightness change: takes effect on the next cycle; no glitch filtering is required.
- Polarity parameters invert only the final output registers; the reset value is the inactive level after inversion.

Test Plan (NUM_DIGITS=4, REFRESH_LOG2=4, PWM_BITS=2, polarities 0, brightness=3, blank=0 unless stated):
- Reset: hold rstn low mid-frame with load pending -> seven_seg=00, anode=0000, frame_tick=0. After release, shadow=0, so the first frame shows digit pattern 3F on each anode in order 0001,0010,0100,1000, 16 cycles each.
- Load/decode: load display_value=16'hA5C3, dp_in=4'b0100 -> from the next frame, digit0=4F, digit1=39, digit2=ED (6D plus dp), digit3=77. frame_tick pulses every 64 cycles.
- Tear-free buffering:
  - load 16'h1111 then 16'h2222 mid-frame -> the current frame stays unchanged; the next frame shows all 5B.
  - load in the boundary cycle -> the new value is visible in that frame.
- PWM: brightness=0 -> each anode high 4 of 16 cycles per slot (phase 0 only). brightness=2 -> 12 of 16. brightness=3 -> 16 of 16.
- Blank: blank=4'b0010 -> anode bit1 never asserts, and seven_seg=00 throughout slot 1; other digits are unaffected.
- Polarity: ACTIVE_LOW_SEG=1, ACTIVE_LOW_AN=1 -> reset gives seven_seg=FF, anode=1111; digit '0' is driven as C0 with its anode bit low.
